das_mul_arbiter: RTL and testbench

- Time-shares one unsigned 8x13 -> 20-bit multiplier between NUM_REQ delay-and-sum channel requesters (sample x weight products).
- Round-robin arbitration, valid/ready handshakes on every requester and on the single result port.
- The result carries the requester ID so downstream accumulators can demultiplex it.
- Two-stage pipeline; full throughput of one product per cycle when there is no backpressure.

---
 rtl/das_mul_pkg.sv | 39 +++
 rtl/das_mul_unit.sv | 45 ++++
 rtl/das_mul_arbiter.sv | 170 +++++++++++++++++
 tb/tb_das_mul_arbiter.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/das_mul_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : das_mul_pkg
//  Purpose  : Shared constants, ID-width helper and pipeline record types for
//             the delay-and-sum multiplier arbiter.
//  Contents : DAS_A_W / DAS_B_W / DAS_P_W  default operand/result widths
//             DAS_ID_MAX_W                 ID field width (covers 16 requesters)
//             das_id_w()                   requester-ID width for N requesters
//             das_s1_t                     operand stage record {a, b, id}
//             das_s2_t                     result stage record {data, ovf, id}
//  Revision : 1.0  initial release
// ============================================================================
package das_mul_pkg;

  localparam int unsigned DAS_A_W      = 8;
  localparam int unsigned DAS_B_W      = 13;
  localparam int unsigned DAS_P_W      = 20;
  // Widest ID ever needed (16 requesters); narrower IDs are zero-extended.
  localparam int unsigned DAS_ID_MAX_W = 4;

  // At least one ID bit is kept even for the 2-requester case.
  function automatic int unsigned das_id_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  typedef struct packed {
    logic [DAS_A_W-1:0]      a;
    logic [DAS_B_W-1:0]      b;
    logic [DAS_ID_MAX_W-1:0] id;
  } das_s1_t;

  typedef struct packed {
    logic [DAS_P_W-1:0]      data;
    logic                    ovf;
    logic [DAS_ID_MAX_W-1:0] id;
  } das_s2_t;

endpackage : das_mul_pkg
`default_nettype wire

// File: rtl/das_mul_unit.sv
`default_nettype none
// ============================================================================
//  Module   : das_mul_unit
//  Purpose  : Combinational unsigned A_W x B_W multiplier. Returns the low
//             P_W bits of the product and flags any set bit above them.
//  Ports    : a_i   [A_W-1:0]  operand A (sample)
//             b_i   [B_W-1:0]  operand B (weight)
//             p_o   [P_W-1:0]  truncated product
//             ovf_o            1 when the full product is >= 2^P_W
//  Revision : 1.0  initial release
// ============================================================================
module das_mul_unit
  import das_mul_pkg::*;
#(
  parameter int unsigned A_W = DAS_A_W,
  parameter int unsigned B_W = DAS_B_W,
  parameter int unsigned P_W = DAS_P_W
) (
  input  logic [A_W-1:0] a_i,
  input  logic [B_W-1:0] b_i,
  output logic [P_W-1:0] p_o,
  output logic           ovf_o
);

  localparam int unsigned FULL_W = A_W + B_W;

  logic [FULL_W-1:0] full;

  // Both operands are widened to the full width so the product is not
  // truncated to the wider of the two inputs.
  assign full = {{B_W{1'b0}}, a_i} * {{A_W{1'b0}}, b_i};

  generate
    if (P_W < FULL_W) begin : g_trunc
      assign p_o   = full[P_W-1:0];
      assign ovf_o = |full[FULL_W-1:P_W];
    end else begin : g_wide
      // Result port is wide enough for any product: no overflow possible.
      assign p_o   = P_W'(full);
      assign ovf_o = 1'b0;
    end
  endgenerate

endmodule : das_mul_unit
`default_nettype wire

// File: rtl/das_mul_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : das_mul_arbiter
//  Purpose  : Round-robin time-sharing of one unsigned multiplier among
//             NUM_REQ requesters, with a two-stage pipeline (operand register
//             S1, result register S2) and valid/ready on every port.
//  Ports    : ap_clk              clock, rising edge
//             ap_rst_n            asynchronous active-low reset
//             req_valid [N]       per-requester operand valid
//             req_ready [N]       per-requester accept, one-hot or zero
//             req_a     [N*A_W]   packed operand A, requester i at [i*A_W +: A_W]
//             req_b     [N*B_W]   packed operand B, same packing
//             res_valid           result valid
//             res_ready           downstream accept
//             res_id    [ID_W]    requester that owns the result
//             res_data  [P_W]     low P_W bits of a*b
//             res_ovf             full product >= 2^P_W
//  Note     : The S1/S2 records are sized by the package width constants, so
//             A_W/B_W/P_W must match DAS_A_W/DAS_B_W/DAS_P_W.
//  Revision : 1.0  initial release
// ============================================================================
module das_mul_arbiter
  import das_mul_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned A_W     = DAS_A_W,
  parameter int unsigned B_W     = DAS_B_W,
  parameter int unsigned P_W     = DAS_P_W,
  parameter int unsigned ID_W    = das_id_w(NUM_REQ)
) (
  input  logic                   ap_clk,
  input  logic                   ap_rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*A_W-1:0] req_a,
  input  logic [NUM_REQ*B_W-1:0] req_b,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [ID_W-1:0]        res_id,
  output logic [P_W-1:0]         res_data,
  output logic                   res_ovf
);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic            v1_q, v1_d;
  logic            v2_q, v2_d;
  das_s1_t         s1_q, s1_d;
  das_s2_t         s2_q, s2_d;
  logic [ID_W-1:0] ptr_q, ptr_d;

  // --------------------------------------------------------------------------
  // Pipeline advance conditions
  // --------------------------------------------------------------------------
  logic adv1, adv2;

  assign adv2 = !v2_q || res_ready;
  assign adv1 = !v1_q || adv2;

  // --------------------------------------------------------------------------
  // Round-robin search starting at ptr_q with wrap-around. The scan runs from
  // the farthest offset down to offset 0 so the nearest valid requester is the
  // last one written and therefore wins.
  // --------------------------------------------------------------------------
  logic            gnt_found;
  logic [ID_W-1:0] gnt_idx;
  logic            fire;

  always_comb begin : p_arb
    logic [ID_W:0] cand;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = {1'b0, ptr_q} + (ID_W + 1)'(k);
      if (cand >= (ID_W + 1)'(NUM_REQ)) begin
        cand = cand - (ID_W + 1)'(NUM_REQ);
      end
      if (req_valid[cand[ID_W-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand[ID_W-1:0];
      end
    end
  end

  // A grant is only offered while S1 can accept; ready is forced low during
  // reset so nothing appears accepted while the pipeline is being cleared.
  assign fire      = adv1 && gnt_found;
  assign req_ready = (ap_rst_n && fire) ? (NUM_REQ'(1) << gnt_idx) : '0;

  // --------------------------------------------------------------------------
  // Multiplier on the S1 operands
  // --------------------------------------------------------------------------
  logic [P_W-1:0] mul_p;
  logic           mul_ovf;

  das_mul_unit #(
    .A_W (A_W),
    .B_W (B_W),
    .P_W (P_W)
  ) u_mul (
    .a_i   (s1_q.a),
    .b_i   (s1_q.b),
    .p_o   (mul_p),
    .ovf_o (mul_ovf)
  );

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin : p_s1_next
    v1_d  = v1_q;
    s1_d  = s1_q;
    ptr_d = ptr_q;
    if (adv1) begin
      v1_d = fire;
      if (fire) begin
        s1_d.a  = req_a[gnt_idx*A_W +: A_W];
        s1_d.b  = req_b[gnt_idx*B_W +: B_W];
        s1_d.id = DAS_ID_MAX_W'(gnt_idx);
        ptr_d   = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
      end
    end
  end

  // When S2 advances without a valid operand only the valid bit drops; the
  // payload is held so the outputs do not toggle needlessly.
  always_comb begin : p_s2_next
    v2_d = v2_q;
    s2_d = s2_q;
    if (adv2) begin
      v2_d = v1_q;
      if (v1_q) begin
        s2_d.data = mul_p;
        s2_d.ovf  = mul_ovf;
        s2_d.id   = s1_q.id;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin : p_regs
    if (!ap_rst_n) begin
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      s1_q  <= '0;
      s2_q  <= '0;
      ptr_q <= '0;
    end else begin
      v1_q  <= v1_d;
      v2_q  <= v2_d;
      s1_q  <= s1_d;
      s2_q  <= s2_d;
      ptr_q <= ptr_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs come straight from S2
  // --------------------------------------------------------------------------
  assign res_valid = v2_q;
  assign res_id    = s2_q.id[ID_W-1:0];
  assign res_data  = s2_q.data;
  assign res_ovf   = s2_q.ovf;

endmodule : das_mul_arbiter
`default_nettype wire

// File: tb/tb_das_mul_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_das_mul_arbiter
//  Purpose  : Self-checking bench for das_mul_arbiter (4 requesters, 8x13->20)
//  Revision : 1.0  initial release
// ============================================================================
module tb_das_mul_arbiter;

  logic        ap_clk;
  logic        ap_rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_a;
  logic [51:0] req_b;
  logic        res_valid;
  logic        res_ready;
  logic [1:0]  res_id;
  logic [19:0] res_data;
  logic        res_ovf;

  int n_checks = 0;
  int n_errors = 0;

  das_mul_arbiter #(
    .NUM_REQ (4),
    .A_W     (8),
    .B_W     (13),
    .P_W     (20)
  ) dut (
    .ap_clk    (ap_clk),
    .ap_rst_n  (ap_rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_id    (res_id),
    .res_data  (res_data),
    .res_ovf   (res_ovf)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  typedef struct packed {
    logic [3:0]  valid;
    logic [31:0] a;
    logic [51:0] b;
    logic        rr;
    logic [3:0]  exp_ready;
    logic        exp_rv;
    logic [1:0]  exp_id;
    logic [19:0] exp_data;
    logic        exp_ovf;
  } vec_t;

  localparam int NV = 20;
  vec_t tv [NV];

  localparam logic [31:0] A_RR = {8'd4, 8'd3, 8'd2, 8'd1};
  localparam logic [51:0] B_RR = {13'd10, 13'd10, 13'd10, 13'd10};
  localparam logic [31:0] A_S1 = {8'd0, 8'd0, 8'd100, 8'd0};
  localparam logic [51:0] B_S1 = {13'd0, 13'd0, 13'd200, 13'd0};
  localparam logic [31:0] A_OV = {8'd0, 8'd255, 8'd0, 8'd0};
  localparam logic [51:0] B_OV = {13'd0, 13'd8191, 13'd0, 13'd0};
  localparam logic [31:0] A_WR = {8'd255, 8'd0, 8'd0, 8'd7};
  localparam logic [51:0] B_WR = {13'd4112, 13'd0, 13'd0, 13'd9};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic set_op(input int i, input int a, input int b);
    req_a[i*8 +: 8]   = 8'(a);
    req_b[i*13 +: 13] = 13'(b);
  endtask

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic chk_res(input string tag, input logic [1:0] id, input logic [19:0] data,
                         input logic ovf);
    chk({tag, ".res_valid"}, 32'(res_valid), 32'd1);
    chk({tag, ".res_id"}, 32'(res_id), 32'(id));
    chk({tag, ".res_data"}, 32'(res_data), 32'(data));
    chk({tag, ".res_ovf"}, 32'(res_ovf), 32'(ovf));
  endtask

  // Hold reset for two edges with every requester asserting, check the reset
  // state, then release on a falling edge.
  task automatic do_reset();
    ap_rst_n  = 1'b0;
    req_valid = 4'b1111;
    req_a     = '1;
    req_b     = '1;
    res_ready = 1'b1;
    @(negedge ap_clk);
    chk("rst.req_ready", 32'(req_ready), 32'd0);
    chk("rst.res_valid", 32'(res_valid), 32'd0);
    chk("rst.res_id", 32'(res_id), 32'd0);
    chk("rst.res_data", 32'(res_data), 32'd0);
    chk("rst.res_ovf", 32'(res_ovf), 32'd0);
    @(posedge ap_clk);
    @(negedge ap_clk);
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    ap_rst_n  = 1'b1;
    tick();
  endtask

  initial begin
    int          n_fire;
    logic [3:0]  bp_ready [5];

    ap_rst_n  = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    res_ready = 1'b1;

    //           valid    a     b     rr    ready    rv    id    data          ovf
    tv[0]  = '{4'b1111, A_RR, B_RR, 1'b1, 4'b0001, 1'b0, 2'd0, 20'd0,       1'b0};
    tv[1]  = '{4'b1111, A_RR, B_RR, 1'b1, 4'b0010, 1'b0, 2'd0, 20'd0,       1'b0};
    tv[2]  = '{4'b1111, A_RR, B_RR, 1'b1, 4'b0100, 1'b1, 2'd0, 20'd10,      1'b0};
    tv[3]  = '{4'b1111, A_RR, B_RR, 1'b1, 4'b1000, 1'b1, 2'd1, 20'd20,      1'b0};
    tv[4]  = '{4'b0000, A_RR, B_RR, 1'b1, 4'b0000, 1'b1, 2'd2, 20'd30,      1'b0};
    tv[5]  = '{4'b0000, A_RR, B_RR, 1'b1, 4'b0000, 1'b1, 2'd3, 20'd40,      1'b0};
    tv[6]  = '{4'b0000, A_RR, B_RR, 1'b1, 4'b0000, 1'b0, 2'd0, 20'd0,       1'b0};
    tv[7]  = '{4'b0010, A_S1, B_S1, 1'b1, 4'b0010, 1'b0, 2'd0, 20'd0,       1'b0};
    tv[8]  = '{4'b0000, A_S1, B_S1, 1'b1, 4'b0000, 1'b0, 2'd0, 20'd0,       1'b0};
    tv[9]  = '{4'b0000, A_S1, B_S1, 1'b1, 4'b0000, 1'b1, 2'd1, 20'd20000,   1'b0};
    tv[10] = '{4'b0000, A_S1, B_S1, 1'b1, 4'b0000, 1'b0, 2'd0, 20'd0,       1'b0};
    tv[11] = '{4'b0100, A_OV, B_OV, 1'b1, 4'b0100, 1'b0, 2'd0, 20'd0,       1'b0};
    tv[12] = '{4'b0000, A_OV, B_OV, 1'b1, 4'b0000, 1'b0, 2'd0, 20'd0,       1'b0};
    tv[13] = '{4'b0000, A_OV, B_OV, 1'b1, 4'b0000, 1'b1, 2'd2, 20'd1040129, 1'b1};
    tv[14] = '{4'b0000, A_OV, B_OV, 1'b1, 4'b0000, 1'b0, 2'd0, 20'd0,       1'b0};
    tv[15] = '{4'b1001, A_WR, B_WR, 1'b1, 4'b1000, 1'b0, 2'd0, 20'd0,       1'b0};
    tv[16] = '{4'b1001, A_WR, B_WR, 1'b1, 4'b0001, 1'b0, 2'd0, 20'd0,       1'b0};
    tv[17] = '{4'b0000, A_WR, B_WR, 1'b1, 4'b0000, 1'b1, 2'd3, 20'd1048560, 1'b0};
    tv[18] = '{4'b0000, A_WR, B_WR, 1'b1, 4'b0000, 1'b1, 2'd0, 20'd63,      1'b0};
    tv[19] = '{4'b0000, A_WR, B_WR, 1'b1, 4'b0000, 1'b0, 2'd0, 20'd0,       1'b0};

    bp_ready[0] = 4'b0001;
    bp_ready[1] = 4'b0100;
    bp_ready[2] = 4'b0000;
    bp_ready[3] = 4'b0000;
    bp_ready[4] = 4'b0000;

    // ---------------- table: round-robin, single, overflow, wrap ----------
    do_reset();
    for (int i = 0; i < NV; i++) begin
      req_valid = tv[i].valid;
      req_a     = tv[i].a;
      req_b     = tv[i].b;
      res_ready = tv[i].rr;
      @(negedge ap_clk);
      chk($sformatf("vec%0d.req_ready", i), 32'(req_ready), 32'(tv[i].exp_ready));
      chk($sformatf("vec%0d.res_valid", i), 32'(res_valid), 32'(tv[i].exp_rv));
      if (tv[i].exp_rv) begin
        chk($sformatf("vec%0d.res_id", i), 32'(res_id), 32'(tv[i].exp_id));
        chk($sformatf("vec%0d.res_data", i), 32'(res_data), 32'(tv[i].exp_data));
        chk($sformatf("vec%0d.res_ovf", i), 32'(res_ovf), 32'(tv[i].exp_ovf));
      end
      tick();
    end

    // ---------------- backpressure ----------------------------------------
    do_reset();
    res_ready = 1'b0;
    req_valid = 4'b0101;
    set_op(0, 3, 5);
    set_op(2, 6, 7);
    n_fire = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge ap_clk);
      if (|(req_ready & req_valid)) n_fire++;
      chk($sformatf("bp%0d.req_ready", c), 32'(req_ready), 32'(bp_ready[c]));
      if (c >= 2) chk_res($sformatf("bp%0d.hold", c), 2'd0, 20'd15, 1'b0);
      tick();
    end
    chk("bp.accepts", 32'(n_fire), 32'd2);
    res_ready = 1'b1;
    @(negedge ap_clk);
    chk("bp.resume_ready", 32'(req_ready), 32'b0001);
    chk_res("bp.drain0", 2'd0, 20'd15, 1'b0);
    tick();
    req_valid = '0;
    @(negedge ap_clk);
    chk("bp.idle_ready", 32'(req_ready), 32'd0);
    chk_res("bp.drain1", 2'd2, 20'd42, 1'b0);
    tick();
    @(negedge ap_clk);
    chk_res("bp.drain2", 2'd0, 20'd15, 1'b0);
    tick();
    @(negedge ap_clk);
    chk("bp.empty", 32'(res_valid), 32'd0);
    tick();

    // ---------------- reset mid-stream ------------------------------------
    // ptr is 1 here; requester 0 is reached by wrap-around.
    req_valid = 4'b0001;
    set_op(0, 3, 5);
    @(negedge ap_clk);
    chk("mr.accept", 32'(req_ready), 32'b0001);
    tick();
    tick();
    ap_rst_n = 1'b0;
    #1;
    chk("mr.res_valid_async", 32'(res_valid), 32'd0);
    @(negedge ap_clk);
    chk("mr.ready_in_reset", 32'(req_ready), 32'd0);
    @(posedge ap_clk);
    @(negedge ap_clk);
    ap_rst_n  = 1'b1;
    req_valid = 4'b0011;
    set_op(1, 9, 9);
    #1;
    chk("mr.grant_after_reset", 32'(req_ready), 32'b0001);
    tick();
    req_valid = '0;
    @(negedge ap_clk);
    chk("mr.no_replay", 32'(res_valid), 32'd0);
    tick();
    @(negedge ap_clk);
    chk_res("mr.result", 2'd0, 20'd15, 1'b0);
    tick();
    @(negedge ap_clk);
    chk("mr.single_beat", 32'(res_valid), 32'd0);
    tick();

    // ---------------- sparse / dropped request ----------------------------
    do_reset();
    req_valid = 4'b1001;
    set_op(0, 2, 3);
    set_op(3, 11, 11);
    @(negedge ap_clk);
    chk("dr.grant0", 32'(req_ready), 32'b0001);
    tick();
    req_valid = '0;
    @(negedge ap_clk);
    chk("dr.idle_ready", 32'(req_ready), 32'd0);
    chk("dr.idle_res", 32'(res_valid), 32'd0);
    tick();
    @(negedge ap_clk);
    chk_res("dr.res0", 2'd0, 20'd6, 1'b0);
    tick();
    req_valid = 4'b0110;
    set_op(1, 4, 5);
    set_op(2, 6, 5);
    @(negedge ap_clk);
    chk("dr.ptr_after_fire", 32'(req_ready), 32'b0010);
    chk("dr.no_res", 32'(res_valid), 32'd0);
    tick();
    @(negedge ap_clk);
    chk("dr.next_grant", 32'(req_ready), 32'b0100);
    tick();
    req_valid = '0;
    @(negedge ap_clk);
    chk_res("dr.res1", 2'd1, 20'd20, 1'b0);
    tick();
    @(negedge ap_clk);
    chk_res("dr.res2", 2'd2, 20'd30, 1'b0);
    tick();
    @(negedge ap_clk);
    chk("dr.empty", 32'(res_valid), 32'd0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_das_mul_arbiter
`default_nettype wire
